// File: rtl/otter_pkg.sv
// Shared types for the OTTER fetch path: next-PC source encoding, fetch FSM
// states and the default reset vector.
package otter_pkg;

  typedef enum logic [2:0] {
    PCSEL_PLUS4  = 3'd0,
    PCSEL_JALR   = 3'd1,
    PCSEL_BRANCH = 3'd2,
    PCSEL_JAL    = 3'd3,
    PCSEL_MTVEC  = 3'd4,
    PCSEL_MEPC   = 3'd5
  } pc_sel_t;

  typedef enum logic {
    FETCH = 1'b0,
    READY = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/otter_pc_mux.sv
// Combinational next-PC selector; reserved select codes fall back to PC+4.
module otter_pc_mux
  import otter_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  input  logic [31:0] jal,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      PCSEL_PLUS4:  next_pc = pc_plus4;
      PCSEL_JALR:   next_pc = jalr;
      PCSEL_BRANCH: next_pc = branch;
      PCSEL_JAL:    next_pc = jal;
      PCSEL_MTVEC:  next_pc = mtvec;
      PCSEL_MEPC:   next_pc = mepc;
      default:      next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/otter_pc_fetch.sv
// Program counter, fetch handshake FSM and retired-instruction counter.
// Misaligned targets are rejected in place and reported via misalign/bad_addr.
module otter_pc_fetch
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int          CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PC_WE,
  input  logic [2:0]       PC_SEL,
  input  logic [31:0]      jal,
  input  logic [31:0]      branch,
  input  logic [31:0]      jalr,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  input  logic             imem_ready,
  output logic [31:0]      PC,
  output logic [31:0]      PC_PLUS4,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic             instr_valid,
  output logic             misalign,
  output logic [31:0]      bad_addr,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  next_pc;
  logic         accept;
  logic         reject;

  assign PC_PLUS4  = PC + 32'd4;
  assign imem_addr = PC;

  otter_pc_mux u_pc_mux (
    .sel      (PC_SEL),
    .pc_plus4 (PC_PLUS4),
    .jalr     (jalr),
    .branch   (branch),
    .jal      (jal),
    .mtvec    (mtvec),
    .mepc     (mepc),
    .next_pc  (next_pc)
  );

  // PC_WE only has an effect once the instruction at PC has been delivered.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          state_next = READY;
        end else begin
          state_next = FETCH;
        end
      end
      READY: begin
        if (PC_WE && is_word_aligned(next_pc)) begin
          accept     = 1'b1;
          state_next = FETCH;
        end else if (PC_WE) begin
          reject     = 1'b1;
          state_next = READY;
        end else begin
          state_next = READY;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they never glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FETCH;
      PC          <= RESET_VEC;
      retired     <= '0;
      bad_addr    <= 32'h0000_0000;
      misalign    <= 1'b0;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      imem_req    <= (state_next == FETCH);
      instr_valid <= (state_next == READY);
      misalign    <= reject;
      if (accept) begin
        PC      <= next_pc;
        retired <= retired + CNT_W'(1);
      end
      if (reject) begin
        bad_addr <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_otter_pc_fetch.sv
// Randomized self-checking bench for otter_pc_fetch against a behavioural model.
module tb_otter_pc_fetch;
  import otter_pkg::*;

  localparam int CW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          PC_WE;
  logic [2:0]    PC_SEL;
  logic [31:0]   jal, branch, jalr, mtvec, mepc;
  logic          imem_ready;
  logic [31:0]   PC, PC_PLUS4, imem_addr, bad_addr;
  logic          imem_req, instr_valid, misalign;
  logic [CW-1:0] retired;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0]   m_pc;
  logic          m_have_instr;
  logic [CW-1:0] m_ret;
  logic [31:0]   m_bad;
  logic          m_mis;

  always #5 CLK = ~CLK;

  otter_pc_fetch #(.RESET_VEC(32'h0000_0000), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .PC_WE(PC_WE), .PC_SEL(PC_SEL),
    .jal(jal), .branch(branch), .jalr(jalr), .mtvec(mtvec), .mepc(mepc),
    .imem_ready(imem_ready), .PC(PC), .PC_PLUS4(PC_PLUS4),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr_valid(instr_valid),
    .misalign(misalign), .bad_addr(bad_addr), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] target(input logic [2:0] sel);
    logic [31:0] t [8];
    t[0] = m_pc + 32'd4; t[1] = jalr;  t[2] = branch; t[3] = jal;
    t[4] = mtvec;        t[5] = mepc;  t[6] = m_pc + 32'd4; t[7] = m_pc + 32'd4;
    return t[sel];
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    if (RST) begin
      m_pc = 32'h0; m_have_instr = 1'b0; m_ret = '0; m_bad = 32'h0; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (!m_have_instr) begin
        if (imem_ready) m_have_instr = 1'b1;
      end else if (PC_WE) begin
        t = target(PC_SEL);
        if (t % 32'd4 == 32'd0) begin
          m_pc = t; m_ret = m_ret + 1'b1; m_have_instr = 1'b0;
        end else begin
          m_bad = t; m_mis = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("pc",          PC,                  m_pc);
    check("pc_plus4",    PC_PLUS4,            m_pc + 32'd4);
    check("imem_addr",   imem_addr,           m_pc);
    check("imem_req",    {31'd0, imem_req},   {31'd0, !m_have_instr});
    check("instr_valid", {31'd0, instr_valid},{31'd0, m_have_instr});
    check("misalign",    {31'd0, misalign},   {31'd0, m_mis});
    check("bad_addr",    bad_addr,            m_bad);
    check("retired",     32'(retired),        32'(m_ret));
  endtask

  task automatic drive(input logic rst, input logic we, input logic [2:0] sel, input logic rdy);
    RST = rst; PC_WE = we; PC_SEL = sel; imem_ready = rdy;
    step();
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    RST = 1'b1; PC_WE = 1'b0; PC_SEL = 3'd0; imem_ready = 1'b0;
    jal = 32'h0; branch = 32'h0; jalr = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    m_pc = 32'h0; m_have_instr = 1'b0; m_ret = '0; m_bad = 32'h0; m_mis = 1'b0;
    #2;
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b1);
    // reset state, then one-cycle fetch
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    // move to 0x100, then PC+4 with three wait cycles
    jal = 32'h100;
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 3'd0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    // PC_SEL sweep including a reserved code
    jalr = 32'h200; branch = 32'h300; jal = 32'h400; mtvec = 32'h500; mepc = 32'h600;
    for (int s = 1; s <= 6; s++) begin
      drive(1'b0, 1'b1, 3'(s), 1'b0);
      drive(1'b0, 1'b0, 3'd0, 1'b1);
    end
    // misaligned jal: rejected, single-cycle pulse
    jal = 32'h402;
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    // PC+4 wrap at top of address space
    jal = 32'hFFFF_FFFC;
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 3'd0, 1'b0);
    // PC_WE during FETCH is ignored; reset wins over imem_ready
    jal = 32'h0000_0800;
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    drive(1'b1, 1'b1, 3'd3, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    // random traffic, long enough to wrap the narrow counter
    for (int i = 0; i < 3000; i++) begin
      jal = rnd_tgt(); branch = rnd_tgt(); jalr = rnd_tgt();
      mtvec = rnd_tgt(); mepc = rnd_tgt();
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
            3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
